// File: rtl/mont_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mont_operand_sequencer
// Description : Operand front end for the Montgomery systolic PE row.
//               Latches A, B and M, forms MB = M + B with a bit-serial
//               adder, then streams A LSB-first on the shared ai line
//               while holding {0,B}, {0,M} and MB stable on the PE inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module mont_operand_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIDTH-1:0]         a_in,
  input  logic [WIDTH-1:0]         b_in,
  input  logic [WIDTH-1:0]         m_in,
  output logic                     busy,
  output logic                     ai_o,
  output logic                     ai_valid,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic [WIDTH:0]           b_o,
  output logic [WIDTH:0]           m_o,
  output logic [WIDTH:0]           mb_o,
  output logic                     done
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRECOMP = 2'd1,
    S_STREAM  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [WIDTH-1:0]  m_reg;
  // Low WIDTH-1 sum bits; the top sum bit and carry-out go straight into
  // mb_out on the final adder cycle, so they never need to be stored here.
  logic [WIDTH-2:0]  mb_acc;
  logic              carry;
  logic [CW-1:0]     cnt;
  logic [WIDTH:0]    b_out;
  logic [WIDTH:0]    m_out;
  logic [WIDTH:0]    mb_out;

  logic              last;
  logic              sum_bit;
  logic              carry_next;

  assign last       = (cnt == LAST);
  assign sum_bit    = b_reg[cnt] ^ m_reg[cnt] ^ carry;
  assign carry_next = (b_reg[cnt] & m_reg[cnt]) | (b_reg[cnt] & carry) | (m_reg[cnt] & carry);

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and status outputs
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    ai_valid   = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = S_PRECOMP;
        end
      end
      S_PRECOMP: begin
        if (last) begin
          state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        ai_valid = 1'b1;
        if (last) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand capture, bit-serial MB adder, stream counter and PE operand regs
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      m_reg  <= '0;
      mb_acc <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      b_out  <= '0;
      m_out  <= '0;
      mb_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg  <= a_in;
            b_reg  <= b_in;
            m_reg  <= m_in;
            mb_acc <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            // PE operands drop to zero while the new MB is being formed
            b_out  <= '0;
            m_out  <= '0;
            mb_out <= '0;
          end
        end
        S_PRECOMP: begin
          // Sum bits enter at the top so bit cnt ends up at position cnt
          mb_acc <= {sum_bit, mb_acc[WIDTH-2:1]};
          carry  <= carry_next;
          if (last) begin
            cnt    <= '0;
            b_out  <= {1'b0, b_reg};
            m_out  <= {1'b0, m_reg};
            mb_out <= {carry_next, sum_bit, mb_acc};
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STREAM: begin
          cnt <= last ? '0 : cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign bit_idx = ai_valid ? cnt : '0;
  assign ai_o    = ai_valid & a_reg[cnt];
  assign b_o     = b_out;
  assign m_o     = m_out;
  assign mb_o    = mb_out;

endmodule
`default_nettype wire

// File: tb/tb_mont_operand_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mont_operand_sequencer
// Description : Self-checking bench for mont_operand_sequencer (WIDTH=8).
//               Directed vector table plus hand-written multi-cycle cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mont_operand_sequencer;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_in, b_in, m_in;
  logic       busy, ai_o, ai_valid, done;
  logic [2:0] bit_idx;
  logic [8:0] b_o, m_o, mb_o;

  always #5 clk = ~clk;

  mont_operand_sequencer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .m_in     (m_in),
    .busy     (busy),
    .ai_o     (ai_o),
    .ai_valid (ai_valid),
    .bit_idx  (bit_idx),
    .b_o      (b_o),
    .m_o      (m_o),
    .mb_o     (mb_o),
    .done     (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] m;
    logic [8:0] mb;
    logic [7:0] ai_bits;
  } vec_t;

  vec_t vecs[6];

  // Results of the most recent run_op
  logic [8:0] res_mb, res_b, res_m, res_mbpre, res_hold_mb;
  logic [7:0] res_ai;
  logic       res_idle_busy;
  int         res_vcnt, res_first, res_done, res_gaps, res_idx_bad, res_mb_unstable;

  // Issue one start (cycle 1 = first cycle after the accepting edge) and
  // observe until done or a 40-cycle bound; optionally pulse start with
  // different operands at cycle inject_cyc.
  task run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m, input int inject_cyc);
    res_ai = '0; res_mb = '0; res_b = '0; res_m = '0; res_mbpre = '0;
    res_vcnt = 0; res_first = -1; res_done = -1; res_gaps = 0;
    res_idx_bad = 0; res_mb_unstable = 0;
    @(negedge clk);
    a_in = a; b_in = b; m_in = m; start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      start = (c == inject_cyc);
      if (c == inject_cyc) begin
        a_in = ~a; b_in = b ^ 8'h5A; m_in = m + 8'd17;
      end
      if (c == 1) res_mbpre = mb_o;
      if (!busy) res_gaps++;
      if (ai_valid) begin
        if (res_first < 0) res_first = c;
        if (bit_idx != res_vcnt[2:0]) res_idx_bad++;
        if (res_vcnt > 0 && mb_o != res_mb) res_mb_unstable++;
        res_ai = {ai_o, res_ai[7:1]};
        res_mb = mb_o; res_b = b_o; res_m = m_o;
        res_vcnt++;
      end
      if (done) begin
        res_done = c;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    res_idle_busy = busy;
    res_hold_mb   = mb_o;
  endtask

  task check_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                input logic [7:0] m, input logic [8:0] mb);
    check({tag, " mb_o"},        {23'd0, res_mb}, {23'd0, mb});
    check({tag, " b_o"},         {23'd0, res_b},  {23'd0, 1'b0, b});
    check({tag, " m_o"},         {23'd0, res_m},  {23'd0, 1'b0, m});
    check({tag, " ai seq"},      {24'd0, res_ai}, {24'd0, a});
    check({tag, " valid count"}, res_vcnt, 8);
    check({tag, " first valid"}, res_first, 9);
    check({tag, " done cycle"},  res_done, 17);
    check({tag, " busy gaps"},   res_gaps, 0);
    check({tag, " bit_idx"},     res_idx_bad, 0);
    check({tag, " mb stable"},   res_mb_unstable, 0);
    check({tag, " mb in precomp"}, {23'd0, res_mbpre}, 32'd0);
    check({tag, " idle busy"},   {31'd0, res_idle_busy}, 32'd0);
    check({tag, " mb hold"},     {23'd0, res_hold_mb}, {23'd0, mb});
  endtask

  int         n_done;
  int         d_cyc[4];
  int         vc;
  logic [7:0] ra, rb, rm;

  initial begin
    vecs[0] = '{a: 8'hA5, b: 8'h3C, m: 8'hC7, mb: 9'h103, ai_bits: 8'hA5};
    vecs[1] = '{a: 8'h12, b: 8'hFF, m: 8'hFF, mb: 9'h1FE, ai_bits: 8'h12};
    vecs[2] = '{a: 8'h96, b: 8'h00, m: 8'h00, mb: 9'h000, ai_bits: 8'h96};
    vecs[3] = '{a: 8'h5A, b: 8'h01, m: 8'hFF, mb: 9'h100, ai_bits: 8'h5A};
    vecs[4] = '{a: 8'hC3, b: 8'h80, m: 8'h80, mb: 9'h100, ai_bits: 8'hC3};
    vecs[5] = '{a: 8'h0F, b: 8'h12, m: 8'h34, mb: 9'h046, ai_bits: 8'h0F};

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; m_in = '0;
    repeat (2) @(negedge clk);
    check("reset ctl", {27'd0, busy, ai_valid, done, ai_o, bit_idx}, 32'd0);
    check("reset b/m", {14'd0, b_o, m_o}, 32'd0);
    check("reset mb",  {23'd0, mb_o}, 32'd0);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].m, 0);
      check_op($sformatf("vec%0d", i), vecs[i].ai_bits, vecs[i].b, vecs[i].m, vecs[i].mb);
    end

    // start with new operands at STREAM bit 3 is ignored
    run_op(8'hA5, 8'h3C, 8'hC7, 12);
    check_op("midstream start", 8'hA5, 8'h3C, 8'hC7, 9'h103);
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("midstream no rerun", n_done, 0);

    // start during DONE is ignored
    run_op(8'h3C, 8'h55, 8'h0A, 17);
    check_op("done-cycle start", 8'h3C, 8'h55, 8'h0A, 9'h05F);

    // Reset during PRECOMP cycle 4
    @(negedge clk);
    a_in = 8'hE1; b_in = 8'h77; m_in = 8'h99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("precomp rst ctl", {27'd0, busy, ai_valid, done, ai_o, bit_idx}, 32'd0);
    check("precomp rst b/m", {14'd0, b_o, m_o}, 32'd0);
    check("precomp rst mb",  {23'd0, mb_o}, 32'd0);
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("precomp rst quiet", n_done, 0);
    run_op(8'h81, 8'h40, 8'h41, 0);
    check_op("after precomp rst", 8'h81, 8'h40, 8'h41, 9'h081);

    // Reset during STREAM, when b_o/m_o/mb_o are populated
    @(negedge clk);
    a_in = 8'hFF; b_in = 8'hAB; m_in = 8'hCD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("stream pre-rst mb", {23'd0, mb_o}, 32'h178);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("stream rst ctl", {27'd0, busy, ai_valid, done, ai_o, bit_idx}, 32'd0);
    check("stream rst b/m", {14'd0, b_o, m_o}, 32'd0);
    check("stream rst mb",  {23'd0, mb_o}, 32'd0);

    // Back-to-back with start held high
    @(negedge clk);
    a_in = 8'h69; b_in = 8'h21; m_in = 8'h43; start = 1'b1;
    n_done = 0; vc = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (ai_valid) vc++;
      if (done && n_done < 4) begin
        d_cyc[n_done] = c;
        n_done++;
      end
    end
    start = 1'b0;
    check("b2b done count", n_done, 3);
    check("b2b first done", d_cyc[0], 17);
    check("b2b period 1", d_cyc[1] - d_cyc[0], 18);
    check("b2b period 2", d_cyc[2] - d_cyc[1], 18);
    check("b2b valid count", vc, 24);
    n_done = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy) begin
        n_done = c;
        break;
      end
    end
    check("b2b drains", {31'd0, n_done >= 0}, 32'd1);
    repeat (2) @(negedge clk);

    // Randomised operands
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rm = 8'($urandom);
      run_op(ra, rb, rm, 0);
      check("rand mb", {23'd0, res_mb}, {23'd0, {1'b0, rb} + {1'b0, rm}});
      check("rand ai", {24'd0, res_ai}, {24'd0, ra});
      check("rand vcnt", res_vcnt, 8);
      check("rand done", res_done, 17);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
